// File: rtl/snitch_mem_pkg.sv
// Shared types and helpers for the Snitch memory bridge.
// Holds the AMO opcode and FSM enums, lane strobes, and lane helpers.
package snitch_mem_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9
  } amo_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WR = 1'b1
  } state_e;

  localparam logic [7:0] STRB_LO = 8'h0F;
  localparam logic [7:0] STRB_HI = 8'hF0;

  function automatic logic amo_supported(
    input logic [3:0] op
  );
    return (op >= 4'h1) && (op <= 4'h9);
  endfunction

  // sel=1 picks the upper 32-bit lane of a 64-bit beat.
  function automatic logic [31:0] lane_get(
    input logic        sel,
    input logic [63:0] beat
  );
    return sel ? beat[63:32] : beat[31:0];
  endfunction

  function automatic logic [63:0] lane_put(
    input logic        sel,
    input logic [31:0] word
  );
    return sel ? {word, 32'h0} : {32'h0, word};
  endfunction

endpackage

// File: rtl/snitch_amo_alu.sv
// Combinational AMO ALU: op, old memory word and operand -> new word.
// Ports: op_i (AMO opcode), old_i, opnd_i (32b), res_o (32b result).
module snitch_amo_alu
  import snitch_mem_pkg::*;
(
  input  amo_op_e     op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] opnd_i,
  output logic [31:0] res_o
);

  logic s_gt;
  logic u_gt;

  always_comb begin
    s_gt  = $signed(old_i) > $signed(opnd_i);
    u_gt  = old_i > opnd_i;
    res_o = old_i;
    unique case (op_i)
      AMO_SWAP: res_o = opnd_i;
      AMO_ADD:  res_o = old_i + opnd_i;
      AMO_AND:  res_o = old_i & opnd_i;
      AMO_OR:   res_o = old_i | opnd_i;
      AMO_XOR:  res_o = old_i ^ opnd_i;
      AMO_MAX:  res_o = s_gt ? old_i : opnd_i;
      AMO_MAXU: res_o = u_gt ? old_i : opnd_i;
      AMO_MIN:  res_o = s_gt ? opnd_i : old_i;
      AMO_MINU: res_o = u_gt ? opnd_i : old_i;
      default:  res_o = old_i;
    endcase
  end

endmodule

// File: rtl/snitch_mem_bridge.sv
// Serves Snitch fetch and data ports from one 64-bit memory port.
// Ports: inst_* fetch, data_q*/data_p* data req/resp, mem_* memory.
module snitch_mem_bridge
  import snitch_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   inst_addr_i,
  input  logic                   inst_valid_i,
  output logic                   inst_ready_o,
  output logic [31:0]            inst_data_o,
  input  logic [AddrWidth-1:0]   data_qaddr_i,
  input  logic                   data_qwrite_i,
  input  logic [3:0]             data_qamo_i,
  input  logic [DataWidth-1:0]   data_qdata_i,
  input  logic [DataWidth/8-1:0] data_qstrb_i,
  input  logic                   data_qvalid_i,
  output logic                   data_qready_o,
  output logic [DataWidth-1:0]   data_pdata_o,
  output logic                   data_perror_o,
  output logic                   data_pvalid_o,
  input  logic                   data_pready_i,
  output logic                   mem_valid_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_write_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_wstrb_o,
  input  logic                   mem_ready_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic        hold_q, hold_d;
  logic        hold_data_q, hold_data_d;
  logic        pvalid_q, pvalid_d;
  logic        perror_q, perror_d;
  logic [63:0] pdata_q, pdata_d;
  logic [31:0] amo_old_q, amo_old_d;

  logic        is_amo, amo_ok, sel;
  logic        resp_busy, data_req, bad_amo;
  logic        gnt_i, gnt_d, hs;
  logic [31:0] amo_res;
  logic [3:0]  unused_addr_lsb;

  assign unused_addr_lsb = {inst_addr_i[1:0], data_qaddr_i[1:0]};
  assign sel = data_qaddr_i[2];

  snitch_amo_alu i_alu (
    .op_i   (amo_op_e'(data_qamo_i)),
    .old_i  (amo_old_q),
    .opnd_i (lane_get(sel, data_qdata_i)),
    .res_o  (amo_res)
  );

  always_comb begin
    is_amo    = data_qamo_i != 4'h0;
    amo_ok    = amo_supported(data_qamo_i);
    resp_busy = pvalid_q && !data_pready_i;
    data_req  = data_qvalid_i && !resp_busy
             && (!is_amo || amo_ok);
    // Unsupported AMOs never touch memory; they answer with an error.
    bad_amo   = data_qvalid_i && is_amo && !amo_ok
             && !resp_busy && (state_q == IDLE);

    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == IDLE) begin
      // A stalled grant is kept so request fields stay stable.
      if (hold_q) begin
        gnt_d = hold_data_q;
        gnt_i = !hold_data_q;
      end else begin
        gnt_d = data_req && (!inst_valid_i || !last_data_q);
        gnt_i = inst_valid_i && !gnt_d;
      end
    end

    mem_valid_o = !rst_i && ((state_q == AMO_WR) || gnt_i || gnt_d);
    mem_addr_o  = gnt_i ? {inst_addr_i[AddrWidth-1:3], 3'b000}
                        : {data_qaddr_i[AddrWidth-1:3], 3'b000};
    mem_write_o = 1'b0;
    mem_wdata_o = data_qdata_i;
    mem_wstrb_o = data_qstrb_i;
    if (state_q == AMO_WR) begin
      mem_write_o = 1'b1;
      mem_wdata_o = lane_put(sel, amo_res);
      mem_wstrb_o = sel ? STRB_HI : STRB_LO;
    end else if (gnt_d) begin
      mem_write_o = data_qwrite_i && !is_amo;
    end

    hs            = mem_valid_o && mem_ready_i;
    inst_ready_o  = hs && gnt_i;
    inst_data_o   = inst_addr_i[2] ? mem_rdata_i[63:32]
                                   : mem_rdata_i[31:0];
    data_qready_o = (!rst_i && bad_amo)
                 || (hs && ((state_q == AMO_WR) || (gnt_d && !is_amo)));

    state_d     = state_q;
    last_data_d = last_data_q;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    pvalid_d    = pvalid_q;
    perror_d    = perror_q;
    pdata_d     = pdata_q;
    amo_old_d   = amo_old_q;

    if (pvalid_q && data_pready_i) pvalid_d = 1'b0;

    if (hs) begin
      last_data_d = (state_q == AMO_WR) || gnt_d;
      hold_d      = 1'b0;
    end else if (state_q == IDLE) begin
      hold_d      = mem_valid_o;
      hold_data_d = gnt_d;
    end

    if (bad_amo) begin
      pvalid_d = 1'b1;
      perror_d = 1'b1;
      pdata_d  = 64'h0;
    end

    if (state_q == IDLE && hs && gnt_d) begin
      if (is_amo) begin
        amo_old_d = lane_get(sel, mem_rdata_i);
        state_d   = AMO_WR;
      end else if (!data_qwrite_i) begin
        pvalid_d = 1'b1;
        perror_d = 1'b0;
        pdata_d  = mem_rdata_i;
      end
    end

    if (state_q == AMO_WR && hs) begin
      state_d  = IDLE;
      pvalid_d = 1'b1;
      perror_d = 1'b0;
      pdata_d  = lane_put(sel, amo_old_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      hold_q      <= 1'b0;
      hold_data_q <= 1'b0;
      pvalid_q    <= 1'b0;
      perror_q    <= 1'b0;
      pdata_q     <= 64'h0;
      amo_old_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
      pvalid_q    <= pvalid_d;
      perror_q    <= perror_d;
      pdata_q     <= pdata_d;
      amo_old_q   <= amo_old_d;
    end
  end

  assign data_pvalid_o = pvalid_q;
  assign data_perror_o = perror_q;
  assign data_pdata_o  = pdata_q;

endmodule

// File: tb/tb_snitch_mem_bridge.sv
// Scoreboard bench for snitch_mem_bridge.
// Directed vectors push expectations; a negedge monitor checks them.
module tb_snitch_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] qaddr;
  logic        qwrite;
  logic [3:0]  qamo;
  logic [63:0] qdata;
  logic [7:0]  qstrb;
  logic        qvalid;
  logic        qready;
  logic [63:0] pdata;
  logic        perror;
  logic        pvalid;
  logic        pready;
  logic        mvalid;
  logic [31:0] maddr;
  logic        mwrite;
  logic [63:0] mwdata;
  logic [7:0]  mwstrb;
  logic        mready;
  logic [63:0] mrdata;

  always #5 clk = ~clk;

  snitch_mem_bridge dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .inst_addr_i   (inst_addr),
    .inst_valid_i  (inst_valid),
    .inst_ready_o  (inst_ready),
    .inst_data_o   (inst_data),
    .data_qaddr_i  (qaddr),
    .data_qwrite_i (qwrite),
    .data_qamo_i   (qamo),
    .data_qdata_i  (qdata),
    .data_qstrb_i  (qstrb),
    .data_qvalid_i (qvalid),
    .data_qready_o (qready),
    .data_pdata_o  (pdata),
    .data_perror_o (perror),
    .data_pvalid_o (pvalid),
    .data_pready_i (pready),
    .mem_valid_o   (mvalid),
    .mem_addr_o    (maddr),
    .mem_write_o   (mwrite),
    .mem_wdata_o   (mwdata),
    .mem_wstrb_o   (mwstrb),
    .mem_ready_i   (mready),
    .mem_rdata_i   (mrdata)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } inst_exp_t;

  typedef struct {
    logic        err;
    logic [63:0] data;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } wr_exp_t;

  inst_exp_t exp_inst[$];
  resp_exp_t exp_resp[$];
  wr_exp_t   exp_wr[$];
  bit        exp_gnt[$];
  bit        gnt_chk = 1'b0;

  int checks   = 0;
  int failures = 0;

  inst_exp_t ei;
  resp_exp_t er;
  wr_exp_t   ew;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT event with empty scoreboard", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_ready) begin
        if (exp_inst.size() == 0) unexp("inst_unexpected");
        else begin
          ei = exp_inst.pop_front();
          chk("inst_data", inst_data, ei.data);
          chk("inst_addr", maddr, ei.addr);
        end
      end
      if (pvalid && pready) begin
        if (exp_resp.size() == 0) unexp("resp_unexpected");
        else begin
          er = exp_resp.pop_front();
          chk("resp_data", pdata, er.data);
          chk("resp_err", perror, er.err);
        end
      end
      if (mvalid && mready && mwrite) begin
        if (exp_wr.size() == 0) unexp("write_unexpected");
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", maddr, ew.addr);
          chk("wr_data", mwdata, ew.wdata);
          chk("wr_strb", mwstrb, ew.strb);
        end
      end
      if (gnt_chk && mvalid && mready) begin
        if (exp_gnt.size() == 0) unexp("grant_unexpected");
        else chk("grant_is_data", qready, exp_gnt.pop_front());
      end
    end
  end

  task automatic do_amo(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [63:0] opnd,
    input logic [63:0] rd,
    input logic [63:0] wd,
    input logic [7:0]  st,
    input logic [63:0] rsp
  );
    qvalid = 1'b1;
    qwrite = 1'b0;
    qamo   = op;
    qaddr  = addr;
    qdata  = opnd;
    mrdata = rd;
    @(negedge clk);
    chk("amo_rd_qready", qready, 1'b0);
    tick();
    exp_wr.push_back('{addr & 32'hFFFF_FFF8, wd, st});
    exp_resp.push_back('{1'b0, rsp});
    @(negedge clk);
    chk("amo_wr_qready", qready, 1'b1);
    tick();
    qvalid = 1'b0;
    qamo   = 4'h0;
  endtask

  initial begin
    rst        = 1'b1;
    inst_addr  = 32'h0;
    inst_valid = 1'b1;
    qaddr      = 32'h0;
    qwrite     = 1'b0;
    qamo       = 4'h0;
    qdata      = 64'h0;
    qstrb      = 8'hFF;
    qvalid     = 1'b1;
    pready     = 1'b1;
    mready     = 1'b1;
    mrdata     = 64'h0;

    @(negedge clk);
    chk("rst_mem_valid", mvalid, 1'b0);
    chk("rst_inst_ready", inst_ready, 1'b0);
    chk("rst_qready", qready, 1'b0);
    tick();
    rst        = 1'b0;
    inst_valid = 1'b0;
    qvalid     = 1'b0;
    @(negedge clk);
    chk("rst_pvalid", pvalid, 1'b0);
    chk("rst_pdata", pdata, 64'h0);
    chk("rst_perror", perror, 1'b0);
    tick();

    // Fetch, both lanes.
    mrdata     = 64'hAAAA_BBBB_CCCC_DDDD;
    inst_valid = 1'b1;
    inst_addr  = 32'h0001_0004;
    exp_inst.push_back('{32'hAAAA_BBBB, 32'h0001_0000});
    tick();
    inst_addr  = 32'h0001_0000;
    exp_inst.push_back('{32'hCCCC_DDDD, 32'h0001_0000});
    tick();
    inst_valid = 1'b0;

    // Fairness: data, inst, data, inst.
    mrdata     = 64'h0123_4567_89AB_CDEF;
    inst_valid = 1'b1;
    inst_addr  = 32'h20;
    qvalid     = 1'b1;
    qaddr      = 32'h100;
    exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    repeat (2) begin
      exp_resp.push_back('{1'b0, 64'h0123_4567_89AB_CDEF});
      exp_inst.push_back('{32'h89AB_CDEF, 32'h20});
    end
    gnt_chk = 1'b1;
    repeat (4) tick();
    gnt_chk    = 1'b0;
    inst_valid = 1'b0;
    qvalid     = 1'b0;
    tick();

    // Load with response backpressure.
    pready = 1'b0;
    qvalid = 1'b1;
    qaddr  = 32'h200;
    mrdata = 64'h1122_3344_5566_7788;
    exp_resp.push_back('{1'b0, 64'h1122_3344_5566_7788});
    @(negedge clk);
    chk("load_qready", qready, 1'b1);
    tick();
    qaddr      = 32'h208;
    mrdata     = 64'h99AA_BBCC_DDEE_FF00;
    inst_valid = 1'b1;
    inst_addr  = 32'h30;
    repeat (3) begin
      exp_inst.push_back('{32'hDDEE_FF00, 32'h30});
      @(negedge clk);
      chk("bp_qready", qready, 1'b0);
      chk("bp_pvalid", pvalid, 1'b1);
      chk("bp_pdata", pdata, 64'h1122_3344_5566_7788);
      tick();
    end
    inst_valid = 1'b0;
    pready     = 1'b1;
    exp_resp.push_back('{1'b0, 64'h99AA_BBCC_DDEE_FF00});
    @(negedge clk);
    chk("b2b_qready", qready, 1'b1);
    tick();
    qvalid = 1'b0;
    tick();

    // AMO Add with a stalled write phase.
    qvalid = 1'b1;
    qamo   = 4'h2;
    qaddr  = 32'h2000;
    qdata  = 64'h5;
    mrdata = 64'h1234_5678_FFFF_FFFE;
    @(negedge clk);
    chk("add_rd_qready", qready, 1'b0);
    chk("add_rd_write", mwrite, 1'b0);
    tick();
    mready     = 1'b0;
    inst_valid = 1'b1;
    inst_addr  = 32'h40;
    @(negedge clk);
    chk("add_stall_valid", mvalid, 1'b1);
    chk("add_stall_write", mwrite, 1'b1);
    chk("add_stall_qready", qready, 1'b0);
    chk("add_lock_inst", inst_ready, 1'b0);
    tick();
    mready = 1'b1;
    exp_wr.push_back('{32'h2000, 64'h3, 8'h0F});
    exp_resp.push_back('{1'b0, 64'hFFFF_FFFE});
    @(negedge clk);
    chk("add_wr_qready", qready, 1'b1);
    chk("add_wr_inst", inst_ready, 1'b0);
    tick();
    qvalid     = 1'b0;
    qamo       = 4'h0;
    inst_valid = 1'b0;
    tick();

    // Signed vs unsigned compare, upper lane.
    do_amo(4'h6, 32'h3004, {32'h1, 32'h0}, {32'h8000_0000, 32'hDEAD_BEEF},
           {32'h1, 32'h0}, 8'hF0, {32'h8000_0000, 32'h0});
    do_amo(4'h7, 32'h3004, {32'h1, 32'h0}, {32'h8000_0000, 32'hDEAD_BEEF},
           {32'h8000_0000, 32'h0}, 8'hF0, {32'h8000_0000, 32'h0});
    do_amo(4'h8, 32'h3004, {32'h1, 32'h0}, {32'h8000_0000, 32'hDEAD_BEEF},
           {32'h8000_0000, 32'h0}, 8'hF0, {32'h8000_0000, 32'h0});
    do_amo(4'h9, 32'h3004, {32'h1, 32'h0}, {32'h8000_0000, 32'hDEAD_BEEF},
           {32'h1, 32'h0}, 8'hF0, {32'h8000_0000, 32'h0});
    do_amo(4'h5, 32'h3000, 64'hFFFF_0000, 64'h0F0F_0F0F,
           64'hF0F0_0F0F, 8'h0F, 64'h0F0F_0F0F);
    tick();

    // Unsupported AMO (LR).
    qvalid = 1'b1;
    qamo   = 4'hA;
    qaddr  = 32'h5000;
    exp_resp.push_back('{1'b1, 64'h0});
    @(negedge clk);
    chk("bad_qready", qready, 1'b1);
    chk("bad_mem_valid", mvalid, 1'b0);
    tick();
    qvalid = 1'b0;
    qamo   = 4'h0;
    @(negedge clk);
    chk("bad_perror", perror, 1'b1);
    tick();

    // Reset while in the AMO write phase.
    qvalid = 1'b1;
    qamo   = 4'h1;
    qaddr  = 32'h4000;
    qdata  = 64'h7;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstamo_mem_valid", mvalid, 1'b0);
    chk("rstamo_qready", qready, 1'b0);
    tick();
    rst        = 1'b0;
    qvalid     = 1'b0;
    qamo       = 4'h0;
    inst_valid = 1'b1;
    inst_addr  = 32'h50;
    mrdata     = 64'h5555_6666_7777_8888;
    exp_inst.push_back('{32'h7777_8888, 32'h50});
    @(negedge clk);
    chk("rstamo_pvalid", pvalid, 1'b0);
    chk("rstamo_idle_fetch", inst_ready, 1'b1);
    tick();
    inst_valid = 1'b0;
    tick();
    tick();

    chk("scoreboard_drained",
        exp_inst.size() + exp_resp.size() + exp_wr.size() + exp_gnt.size(),
        0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
